// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - DMType encoding, arbiter state and request types for the dmem arbiter
package dmem_pkg;

    localparam logic [2:0] DMT_W  = 3'b000;
    localparam logic [2:0] DMT_H  = 3'b001;
    localparam logic [2:0] DMT_HU = 3'b010;
    localparam logic [2:0] DMT_B  = 3'b011;
    localparam logic [2:0] DMT_BU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_RESP
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  dmtype;
    } dmem_req_t;

    function automatic logic is_misaligned(input logic [2:0] dmtype, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (dmtype)
            DMT_W:         mis = (addr_lo != 2'b00);
            DMT_H, DMT_HU: mis = addr_lo[0];
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// rtl/dmem_arb_starve.sv - saturating count of port-1 lost cycles, raises force_p1 at STARVE_MAX
module dmem_arb_starve #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p1_req_i,
    input  logic p1_gnt_i,
    output logic force_p1_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!p1_req_i || p1_gnt_i) begin
            cnt_d = 8'd0;
        end else if (cnt_q != 8'(STARVE_MAX)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_p1_o = (cnt_q == 8'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of the single-port data memory
// DMEM_ALIGN_CHK_EN adds p0_err/p1_err and blocks misaligned accesses from reaching memory.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wd,
    input  logic [2:0]  p0_dmtype,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wd,
    input  logic [2:0]  p1_dmtype,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [2:0]  mem_dmtype,
    input  logic [31:0] mem_rd,
    output logic        cpu_stall
`ifdef DMEM_ALIGN_CHK_EN
    ,
    output logic        p0_err,
    output logic        p1_err
`endif
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, wd_q;
    logic [2:0]  dmtype_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;
    logic        p0_err_q, p1_err_q;
    logic        force_p1;
    logic        p0_elig, p1_elig, gsel, gnt_any, mis, fwd;
    dmem_req_t   req0, req1, sel;

    assign req0 = '{we: p0_we, addr: p0_addr, wd: p0_wd, dmtype: p0_dmtype};
    assign req1 = '{we: p1_we, addr: p1_addr, wd: p1_wd, dmtype: p1_dmtype};

    dmem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .p1_req_i   (p1_req),
        .p1_gnt_i   (p1_gnt),
        .force_p1_o (force_p1)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        // A port whose error is reported this cycle still holds req; keep it from re-winning.
        p0_elig = p0_req & ~p0_err_q;
        p1_elig = p1_req & ~p1_err_q;
        case (state_q)
            ST_RD_WAIT: begin
                p0_elig = 1'b0;
                p1_elig = 1'b0;
            end
            ST_RD_RESP: begin
                if (owner_q) p1_elig = 1'b0;
                else         p0_elig = 1'b0;
            end
            default: ;
        endcase

        gsel    = p1_elig & (force_p1 | ~p0_elig);
        p1_gnt  = gsel;
        p0_gnt  = p0_elig & ~gsel;
        gnt_any = p0_gnt | p1_gnt;
        sel     = gsel ? req1 : req0;
`ifdef DMEM_ALIGN_CHK_EN
        mis     = is_misaligned(sel.dmtype, sel.addr[1:0]);
`else
        mis     = 1'b0;
`endif
        fwd     = gnt_any & ~mis;

        mem_we     = fwd & sel.we;
        mem_addr   = fwd ? sel.addr   : addr_q;
        mem_wd     = fwd ? sel.wd     : wd_q;
        mem_dmtype = fwd ? sel.dmtype : dmtype_q;

        if (fwd && !sel.we) begin
            state_d = ST_RD_WAIT;
            owner_d = gsel;
        end else if (state_q == ST_RD_WAIT) begin
            state_d = ST_RD_RESP;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            addr_q     <= 32'd0;
            wd_q       <= 32'd0;
            dmtype_q   <= 3'd0;
            p0_rdata_q <= 32'd0;
            p1_rdata_q <= 32'd0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            if (fwd) begin
                addr_q   <= sel.addr;
                wd_q     <= sel.wd;
                dmtype_q <= sel.dmtype;
            end
            // Memory output is valid during RD_WAIT, formatted against the held request.
            if (state_q == ST_RD_WAIT) begin
                if (owner_q) p1_rdata_q <= mem_rd;
                else         p0_rdata_q <= mem_rd;
            end
            p0_err_q <= p0_gnt & mis;
            p1_err_q <= p1_gnt & mis;
        end
    end

    assign p0_rvalid = (state_q == ST_RD_RESP) & ~owner_q;
    assign p1_rvalid = (state_q == ST_RD_RESP) &  owner_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign cpu_stall = p0_req & ~((p0_gnt & p0_we) | p0_rvalid | p0_err_q);

`ifdef DMEM_ALIGN_CHK_EN
    assign p0_err = p0_err_q;
    assign p1_err = p1_err_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized bench for dmem_arbiter with a transaction-level reference model
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int SMAX = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wd, p1_addr, p1_wd;
    logic [2:0]  p0_dmtype, p1_dmtype;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [2:0]  mem_dmtype;
    logic        cpu_stall;
`ifdef DMEM_ALIGN_CHK_EN
    logic        p0_err, p1_err;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wd(p0_wd), .p0_dmtype(p0_dmtype),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wd(p1_wd), .p1_dmtype(p1_dmtype),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_dmtype(mem_dmtype),
        .mem_rd(mem_rd), .cpu_stall(cpu_stall)
`ifdef DMEM_ALIGN_CHK_EN
        , .p0_err(p0_err), .p1_err(p1_err)
`endif
    );

    typedef struct {
        bit          act;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  dmt;
    } trq_t;

    trq_t        rq [2];
    logic [7:0]  dmem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  rd_q;
    logic        init_mem;
    logic [31:0] exp_rd [2];
    int          n_tests = 0, n_fail = 0;
    int          age = 100, own = 0, p1_wait = 0;
    bit          last_g1;

    function automatic int nbytes(input logic [2:0] dmt);
        if (dmt == DMT_W) return 4;
        if (dmt == DMT_H || dmt == DMT_HU) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] fmt(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3,
                                        input logic [2:0] dmt);
        case (dmt)
            DMT_W:   return {b3, b2, b1, b0};
            DMT_H:   return {{16{b1[7]}}, b1, b0};
            DMT_HU:  return {16'h0, b1, b0};
            DMT_B:   return {{24{b0[7]}}, b0};
            default: return {24'h0, b0};
        endcase
    endfunction

    // Data memory: registered read, little-endian lanes, formatter uses the held DMType.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) dmem[i] <= ref_mem[i];
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (i < nbytes(mem_dmtype)) dmem[mem_addr[7:0] + 8'(i)] <= mem_wd[8*i +: 8];
        end
        rd_q <= mem_addr[7:0];
    end
    assign mem_rd = fmt(dmem[rd_q], dmem[rd_q + 8'd1], dmem[rd_q + 8'd2], dmem[rd_q + 8'd3], mem_dmtype);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] dmt);
        for (int i = 0; i < nbytes(dmt); i++) ref_mem[a[7:0] + 8'(i)] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] dmt);
        return fmt(ref_mem[a[7:0]], ref_mem[a[7:0] + 8'd1], ref_mem[a[7:0] + 8'd2],
                   ref_mem[a[7:0] + 8'd3], dmt);
    endfunction

    task automatic drive();
        p0_req = rq[0].act; p0_we = rq[0].we; p0_addr = rq[0].addr; p0_wd = rq[0].wd; p0_dmtype = rq[0].dmt;
        p1_req = rq[1].act; p1_we = rq[1].we; p1_addr = rq[1].addr; p1_wd = rq[1].wd; p1_dmtype = rq[1].dmt;
    endtask

    task automatic arm(input int p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] dmt);
        rq[p].act = 1'b1; rq[p].we = we; rq[p].addr = a; rq[p].wd = wd; rq[p].dmt = dmt;
    endtask

    task automatic arm_rand(input int p);
        bit          we;
        logic [2:0]  dmt;
        logic [31:0] a;
        we = 1'($urandom_range(0, 1));
        if (we) begin
            case ($urandom_range(0, 2))
                0:       dmt = DMT_W;
                1:       dmt = DMT_H;
                default: dmt = DMT_B;
            endcase
        end else begin
            dmt = 3'($urandom_range(0, 4));
        end
        a = 32'($urandom_range(0, 63));
        if (dmt == DMT_W) a[1:0] = 2'b00;
        else if (dmt == DMT_H || dmt == DMT_HU) a[0] = 1'b0;
        arm(p, we, a, $urandom, dmt);
    endtask

    // One clock: drive held requests, compare against the transaction model, advance the model.
    task automatic step();
        bit a0, a1, eg0, eg1, erv0, erv1;
        @(posedge clk); #2;
        drive();
        @(negedge clk);
        a0   = rq[0].act && age != 1 && !(age == 2 && own == 0);
        a1   = rq[1].act && age != 1 && !(age == 2 && own == 1);
        eg1  = a1 && (p1_wait >= SMAX || !a0);
        eg0  = a0 && !eg1;
        erv0 = (age == 2 && own == 0);
        erv1 = (age == 2 && own == 1);
        chk("p0_gnt", 32'(p0_gnt), 32'(eg0));
        chk("p1_gnt", 32'(p1_gnt), 32'(eg1));
        chk("p0_rvalid", 32'(p0_rvalid), 32'(erv0));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(erv1));
        if (erv0) chk("p0_rdata", p0_rdata, exp_rd[0]);
        if (erv1) chk("p1_rdata", p1_rdata, exp_rd[1]);
        chk("cpu_stall", 32'(cpu_stall), 32'(rq[0].act && !((eg0 && rq[0].we) || erv0)));
        chk("mem_we", 32'(mem_we), 32'((eg0 && rq[0].we) || (eg1 && rq[1].we)));
        if (eg0 || eg1) chk("mem_addr", mem_addr, eg1 ? rq[1].addr : rq[0].addr);
        last_g1 = p1_gnt;

        p1_wait = (rq[1].act && !eg1) ? ((p1_wait < SMAX) ? p1_wait + 1 : SMAX) : 0;
        if (age < 100) age++;
        if (erv0) rq[0].act = 1'b0;
        if (erv1) rq[1].act = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if ((p == 0 && eg0) || (p == 1 && eg1)) begin
                if (rq[p].we) begin
                    ref_store(rq[p].addr, rq[p].wd, rq[p].dmt);
                    rq[p].act = 1'b0;
                end else begin
                    exp_rd[p] = ref_load(rq[p].addr, rq[p].dmt);
                    own = p;
                    age = 1;
                end
            end
        end
    endtask

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while ((rq[0].act || rq[1].act) && n < maxc) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(rq[0].act || rq[1].act), 32'd0);
    endtask

    initial begin
        int          lost;
        bit          done;
        logic [31:0] saved;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        rq[0] = '{act: 1'b0, we: 1'b0, addr: 32'd0, wd: 32'd0, dmt: 3'd0};
        rq[1] = rq[0];
        rst_n = 1'b0;
        init_mem = 1'b1;
        drive();
        repeat (2) @(negedge clk);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_mem_dmtype", 32'(mem_dmtype), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        init_mem = 1'b0;

        // p0 word load alone: gnt T, rvalid T+2
        arm(0, 1'b0, 32'h10, 32'd0, DMT_W);
        run_idle(10);
        chk("t1_rdata", p0_rdata, {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]});

        // SB then LBU readback
        arm(0, 1'b1, 32'h23, 32'hFFFFFF5A, DMT_B);
        run_idle(10);
        arm(0, 1'b0, 32'h23, 32'd0, DMT_BU);
        run_idle(10);
        chk("t2_lbu", p0_rdata, 32'h0000005A);

        // simultaneous loads: p1 granted in p0's response cycle
        arm(0, 1'b0, 32'h20, 32'd0, DMT_W);
        arm(1, 1'b0, 32'h24, 32'd0, DMT_H);
        run_idle(12);

        // starvation: p0 store every cycle, p1 store waits exactly SMAX cycles
        step();
        arm(1, 1'b1, 32'h30, $urandom, DMT_W);
        lost = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (!rq[0].act) arm(0, 1'b1, 32'h40 + 32'(4 * (c % 4)), $urandom, DMT_W);
            step();
            if (last_g1) done = 1'b1;
            else lost++;
        end
        chk("t4_lost", 32'(lost), 32'(SMAX));
        run_idle(10);

        // reset in RD_WAIT drops the read
        arm(0, 1'b0, 32'h10, 32'd0, DMT_W);
        step();
        @(posedge clk); #2;
        rst_n = 1'b0;
        rq[0].act = 1'b0;
        rq[1].act = 1'b0;
        drive();
        @(negedge clk);
        chk("t5_rvalid", 32'(p0_rvalid), 32'd0);
        chk("t5_rdata", p0_rdata, 32'd0);
        chk("t5_mem_addr", mem_addr, 32'd0);
        chk("t5_mem_we", 32'(mem_we), 32'd0);
        chk("t5_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        age = 100;
        p1_wait = 0;
        repeat (3) step();
        chk("t5_rdata_after", p0_rdata, 32'd0);
        arm(0, 1'b1, 32'h08, $urandom, DMT_W);
        run_idle(5);

`ifdef DMEM_ALIGN_CHK_EN
        saved = p1_rdata;
        @(posedge clk); #2;
        arm(1, 1'b0, 32'h102, 32'd0, DMT_W);
        drive();
        @(negedge clk);
        chk("t6_gnt", 32'(p1_gnt), 32'd1);
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        chk("t6_err_early", 32'(p1_err), 32'd0);
        @(posedge clk); #2;
        @(negedge clk);
        chk("t6_err", 32'(p1_err), 32'd1);
        chk("t6_regnt", 32'(p1_gnt), 32'd0);
        chk("t6_rvalid", 32'(p1_rvalid), 32'd0);
        @(posedge clk); #2;
        rq[1].act = 1'b0;
        drive();
        @(negedge clk);
        chk("t6_err_end", 32'(p1_err), 32'd0);
        chk("t6_rvalid_end", 32'(p1_rvalid), 32'd0);
        chk("t6_rdata", p1_rdata, saved);
        p1_wait = 0;
`else
        saved = 32'd0;
`endif

        // randomized traffic on both ports
        repeat (1500) begin
            for (int p = 0; p < 2; p++)
                if (!rq[p].act && $urandom_range(0, 2) == 0) arm_rand(p);
            step();
        end
        run_idle(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
